// File: rtl/inst_fetch_pkg.sv
// Shared constants and types for the instruction fetch unit.
// The optional statistics counters are enabled with INST_FETCH_STATS_EN.
package inst_fetch_pkg;

    localparam logic [31:0] INST_NOP         = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h4000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fq_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-side bundle: IMEM request/response, decode handshake and redirect.
// master = fetch unit, slave = environment (IMEM, decode, branch resolution).
interface inst_fetch_if;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [6:0]  opcode;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output imem_en, imem_addr, inst_valid, inst, inst_pc, opcode,
        input  imem_rdata, inst_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_en, imem_addr, inst_valid, inst, inst_pc, opcode,
        output imem_rdata, inst_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/inst_fetch_fetch_queue.sv
// Two-entry {pc, inst} FIFO; entry 0 is always the head.
// Flush has priority over push and pop.
module fetch_queue
    import inst_fetch_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      push_i,
    input  logic      pop_i,
    input  logic      flush_i,
    input  fq_entry_t din_i,
    output logic [1:0] count_o,
    output fq_entry_t head_o
);

    fq_entry_t  ent0_q, ent1_q;
    logic [1:0] count_q, count_d;
    logic [1:0] wr_idx;

    // Write slot is computed after the shift, so push+pop on a full queue lands in entry 1.
    always_comb begin
        wr_idx  = count_q - {1'b0, pop_i};
        count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            ent0_q  <= '0;
            ent1_q  <= '0;
        end else if (flush_i) begin
            count_q <= '0;
        end else begin
            if (pop_i)
                ent0_q <= ent1_q;
            if (push_i) begin
                if (wr_idx == 2'd0)
                    ent0_q <= din_i;
                else
                    ent1_q <= din_i;
            end
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign head_o  = ent0_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: PC, sequential IMEM requests, 2-entry queue to decode.
// Define INST_FETCH_STATS_EN to add fetch_count / redirect_count outputs.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2
) (
    input  logic             clk,
    input  logic             rst,
    inst_fetch_if.master     bus
`ifdef INST_FETCH_STATS_EN
    ,
    output logic [31:0]      fetch_count,
    output logic [31:0]      redirect_count
`endif
);

    logic [31:0] pc_q, req_pc_q;
    logic        inflight_q, epoch_q, req_epoch_q, epoch_d;
    logic [1:0]  count;
    fq_entry_t   head, push_ent;
    logic        inst_valid, pop, push, issue, imem_en;
    logic [2:0]  occ;
    logic [31:0] imem_addr, inst_w;

    assign inst_valid = (count != 2'd0);
    assign pop        = inst_valid && bus.inst_ready;
    assign epoch_d    = epoch_q ^ bus.redirect_valid;

    // Only issue when the response is guaranteed a free slot on return.
    always_comb begin
        occ       = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
        issue     = bus.redirect_valid || (occ < 3'(DEPTH));
        imem_en   = issue && !rst;
        imem_addr = bus.redirect_valid ? word_align(bus.redirect_pc) : pc_q;
    end

    // A stale response carries the old epoch and is discarded.
    assign push          = inflight_q && (req_epoch_q == epoch_q);
    assign push_ent.pc   = req_pc_q;
    assign push_ent.inst = bus.imem_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            req_pc_q    <= '0;
            inflight_q  <= 1'b0;
            epoch_q     <= 1'b0;
            req_epoch_q <= 1'b0;
        end else begin
            inflight_q <= imem_en;
            epoch_q    <= epoch_d;
            if (imem_en) begin
                pc_q        <= imem_addr + 32'd4;
                req_pc_q    <= imem_addr;
                req_epoch_q <= epoch_d;
            end
        end
    end

    fetch_queue u_queue (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (bus.redirect_valid),
        .din_i   (push_ent),
        .count_o (count),
        .head_o  (head)
    );

    assign inst_w         = inst_valid ? head.inst : INST_NOP;
    assign bus.imem_en    = imem_en;
    assign bus.imem_addr  = imem_addr;
    assign bus.inst_valid = inst_valid;
    assign bus.inst       = inst_w;
    assign bus.inst_pc    = inst_valid ? head.pc : 32'h0;
    assign bus.opcode     = inst_w[6:0];

`ifdef INST_FETCH_STATS_EN
    logic [31:0] fetch_count_q, redirect_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count_q    <= '0;
            redirect_count_q <= '0;
        end else begin
            if (pop)
                fetch_count_q <= fetch_count_q + 32'd1;
            if (bus.redirect_valid)
                redirect_count_q <= redirect_count_q + 32'd1;
        end
    end

    assign fetch_count    = fetch_count_q;
    assign redirect_count = redirect_count_q;
`endif

endmodule
